// File: rtl/butterfly_stage_sequencer_if.sv
// Bundle of the sequencer's control, read-address and write-address signals.
// The sequencer drives the master side; the memory/crossbar side uses the slave modport.
interface butterfly_stage_sequencer_if #(
    parameter int unsigned N_LOG2 = 10
);
    logic                i_START;
    logic                i_INVERSE;
    logic                i_STALL;
    logic                o_BUSY;
    logic                o_DONE;
    logic [3:0]          o_STAGE;
    logic [9:0]          o_STRIDE;
    logic                o_RD_EN;
    logic [N_LOG2-3:0]   o_RD_ADDR1;
    logic [N_LOG2-3:0]   o_RD_ADDR2;
    logic                o_WR_EN;
    logic [N_LOG2-3:0]   o_WR_ADDR1;
    logic [N_LOG2-3:0]   o_WR_ADDR2;

    modport master (
        input  i_START, i_INVERSE, i_STALL,
        output o_BUSY, o_DONE, o_STAGE, o_STRIDE,
        output o_RD_EN, o_RD_ADDR1, o_RD_ADDR2,
        output o_WR_EN, o_WR_ADDR1, o_WR_ADDR2
    );

    modport slave (
        output i_START, i_INVERSE, i_STALL,
        input  o_BUSY, o_DONE, o_STAGE, o_STRIDE,
        input  o_RD_EN, o_RD_ADDR1, o_RD_ADDR2,
        input  o_WR_EN, o_WR_ADDR1, o_WR_ADDR2
    );
endinterface

// File: rtl/butterfly_stage_sequencer.sv
// Sequences all N_LOG2 radix-2 stages: one two-row read per cycle, writes replayed through a
// PIPE_LAT-deep delay line, and a drain between stages so no stage reads rows still in flight.
module butterfly_stage_sequencer #(
    parameter int unsigned N_LOG2   = 10,
    parameter int unsigned PIPE_LAT = 4
) (
    input  logic                          i_CLK,
    input  logic                          i_RESET,
    butterfly_stage_sequencer_if.master   io_BUS
);
    localparam int unsigned AW = N_LOG2 - 2;
    localparam int unsigned PW = (N_LOG2 > 3) ? N_LOG2 - 3 : 1;
    localparam int unsigned NP = 1 << (N_LOG2 - 3);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

    state_t          r_state, w_state;
    logic [3:0]      r_stage, w_stage;
    logic [PW-1:0]   r_pair, w_pair;
    logic            r_inverse, w_inverse;

    logic            r_dl_vld [PIPE_LAT];
    logic [AW-1:0]   r_dl_a1  [PIPE_LAT];
    logic [AW-1:0]   r_dl_a2  [PIPE_LAT];

    logic            w_issue;
    logic            w_others;
    logic            w_last_wr;
    logic [3:0]      w_slog;
    logic [3:0]      w_b;
    logic [9:0]      w_stride;
    logic [AW-1:0]   w_mask;
    logic [AW-1:0]   w_p_ext;
    logic [AW-1:0]   w_a1;
    logic [AW-1:0]   w_a2;

    assign w_issue = (r_state == StRun);

    // Stride exponent; rows pair up RS = max(stride/4, 1) apart.
    assign w_slog   = r_inverse ? (4'(N_LOG2 - 1) - r_stage) : r_stage;
    assign w_b      = (w_slog < 4'd2) ? 4'd0 : (w_slog - 4'd2);
    assign w_stride = 10'(1) << w_slog;

    // Insert a zero at bit b of the pair counter to get the top row.
    assign w_p_ext = AW'(r_pair);
    assign w_mask  = (AW'(1) << w_b) - AW'(1);
    assign w_a1    = ((w_p_ext & ~w_mask) << 1) | (w_p_ext & w_mask);
    assign w_a2    = w_a1 + (AW'(1) << w_b);

    always_comb begin
        w_others = 1'b0;
        for (int i = 0; i < int'(PIPE_LAT) - 1; i++) begin
            w_others = w_others | r_dl_vld[i];
        end
    end

    assign w_last_wr = r_dl_vld[PIPE_LAT-1] && !w_others;

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_state   <= StIdle;
            r_stage   <= '0;
            r_pair    <= '0;
            r_inverse <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_stage   <= w_stage;
            r_pair    <= w_pair;
            r_inverse <= w_inverse;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_stage   = r_stage;
        w_pair    = r_pair;
        w_inverse = r_inverse;
        if (!io_BUS.i_STALL) begin
            unique case (r_state)
                StIdle: begin
                    if (io_BUS.i_START) begin
                        w_state   = StRun;
                        w_stage   = '0;
                        w_pair    = '0;
                        w_inverse = io_BUS.i_INVERSE;
                    end
                end
                StRun: begin
                    if (r_pair == PW'(NP - 1)) begin
                        w_state = StDrain;
                        w_pair  = '0;
                    end else begin
                        w_pair = r_pair + PW'(1);
                    end
                end
                StDrain: begin
                    if (w_last_wr) begin
                        if (r_stage == 4'(N_LOG2 - 1)) begin
                            w_state = StDone;
                        end else begin
                            w_state = StRun;
                            w_stage = r_stage + 4'd1;
                        end
                    end
                end
                StDone: begin
                    w_state = StIdle;
                end
                default: begin
                    w_state = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            for (int i = 0; i < int'(PIPE_LAT); i++) begin
                r_dl_vld[i] <= 1'b0;
                r_dl_a1[i]  <= '0;
                r_dl_a2[i]  <= '0;
            end
        end else if (!io_BUS.i_STALL) begin
            r_dl_vld[0] <= w_issue;
            r_dl_a1[0]  <= w_issue ? w_a1 : '0;
            r_dl_a2[0]  <= w_issue ? w_a2 : '0;
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                r_dl_vld[i] <= r_dl_vld[i-1];
                r_dl_a1[i]  <= r_dl_a1[i-1];
                r_dl_a2[i]  <= r_dl_a2[i-1];
            end
        end
    end

    assign io_BUS.o_BUSY     = (r_state != StIdle);
    assign io_BUS.o_DONE     = (r_state == StDone);
    assign io_BUS.o_STAGE    = (w_issue || r_state == StDrain) ? r_stage : 4'd0;
    assign io_BUS.o_STRIDE   = (w_issue || r_state == StDrain) ? w_stride : 10'd0;
    assign io_BUS.o_RD_EN    = w_issue && !io_BUS.i_STALL;
    assign io_BUS.o_RD_ADDR1 = w_issue ? w_a1 : '0;
    assign io_BUS.o_RD_ADDR2 = w_issue ? w_a2 : '0;
    assign io_BUS.o_WR_EN    = r_dl_vld[PIPE_LAT-1] && !io_BUS.i_STALL;
    assign io_BUS.o_WR_ADDR1 = r_dl_vld[PIPE_LAT-1] ? r_dl_a1[PIPE_LAT-1] : '0;
    assign io_BUS.o_WR_ADDR2 = r_dl_vld[PIPE_LAT-1] ? r_dl_a2[PIPE_LAT-1] : '0;

endmodule

// File: tb/tb_butterfly_stage_sequencer.sv
// Directed bench for butterfly_stage_sequencer at N_LOG2=4, PIPE_LAT=4: expected reads are queued
// at start, expected writes queued on each read and popped when the write slot comes due.
module tb_butterfly_stage_sequencer;
    localparam int NL    = 4;
    localparam int PL    = 4;
    localparam int NROWS = 1 << (NL - 2);

    typedef struct {
        int stage;
        int stride;
        int a1;
        int a2;
    } rd_t;

    typedef struct {
        int due;
        int a1;
        int a2;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int    n_cmp  = 0;
    int    n_fail = 0;
    string cur_name = "init";
    int    cur_cyc = 0;

    butterfly_stage_sequencer_if #(.N_LOG2(NL)) bus ();

    butterfly_stage_sequencer #(
        .N_LOG2   (NL),
        .PIPE_LAT (PL)
    ) u_dut (
        .i_CLK   (clk),
        .i_RESET (rst),
        .io_BUS  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s/%s cyc=%0d: got %0h want %0h", cur_name, tag, cur_cyc, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},   32'(bus.o_BUSY), 0);
        check({tag, "_done"},   32'(bus.o_DONE), 0);
        check({tag, "_stage"},  32'(bus.o_STAGE), 0);
        check({tag, "_stride"}, 32'(bus.o_STRIDE), 0);
        check({tag, "_rden"},   32'(bus.o_RD_EN), 0);
        check({tag, "_rda1"},   32'(bus.o_RD_ADDR1), 0);
        check({tag, "_rda2"},   32'(bus.o_RD_ADDR2), 0);
        check({tag, "_wren"},   32'(bus.o_WR_EN), 0);
        check({tag, "_wra1"},   32'(bus.o_WR_ADDR1), 0);
        check({tag, "_wra2"},   32'(bus.o_WR_ADDR2), 0);
    endtask

    function automatic logic [63:0] m8(input int a, b, c, d, e, f, g, h);
        m8 = (64'd1 << a) | (64'd1 << b) | (64'd1 << c) | (64'd1 << d) |
             (64'd1 << e) | (64'd1 << f) | (64'd1 << g) | (64'd1 << h);
    endfunction

    // One transform; cycle 0 drives i_START. rst_c >= 0 aborts with reset at that cycle.
    task automatic run_check(input string name, input bit inv, input logic [63:0] stall_m,
                             input logic [63:0] rd_m, input int poke, input int rst_c,
                             input int exp_done);
        rd_t        rq[$];
        wr_t        wq[$];
        rd_t        r;
        int         uc = 0;
        int         last = (rst_c >= 0) ? rst_c + 1 : exp_done + 1;
        int         last_stride = 0;
        bit         exp_wr;
        bit         exp_busy;
        cur_name = name;
        for (int k = 0; k < NL; k++) begin
            int sl = inv ? (NL - 1 - k) : k;
            int st = 1 << sl;
            int rs = (st < 4) ? 1 : st / 4;
            for (int row = 0; row < NROWS; row++) begin
                if ((row & rs) == 0) rq.push_back('{k, st, row, row + rs});
            end
        end
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            cur_cyc       = c;
            bus.i_START   = (c == 0) || (c == poke);
            bus.i_INVERSE = inv;
            bus.i_STALL   = stall_m[c];
            rst           = (c == rst_c);
            #1;
            if (rst_c >= 0 && c == rst_c + 1) begin
                check_idle("post_reset");
                break;
            end
            if (c >= 1 && !stall_m[c]) uc++;
            check("rd_en", 32'(bus.o_RD_EN), 32'(rd_m[c]));
            if (bus.o_RD_EN === 1'b1) begin
                if (rq.size() == 0) begin
                    check("rd_extra", 32'(rq.size()), 1);
                end else begin
                    r = rq.pop_front();
                    check("rd_a1", 32'(bus.o_RD_ADDR1), r.a1);
                    check("rd_a2", 32'(bus.o_RD_ADDR2), r.a2);
                    check("stride", 32'(bus.o_STRIDE), r.stride);
                    check("stage", 32'(bus.o_STAGE), r.stage);
                    last_stride = r.stride;
                    wq.push_back('{uc + PL, r.a1, r.a2});
                end
            end else if (bus.o_BUSY === 1'b1 && bus.o_DONE !== 1'b1 && last_stride != 0) begin
                check("stride_hold", 32'(bus.o_STRIDE), last_stride);
            end
            exp_wr = !stall_m[c] && wq.size() > 0 && wq[0].due == uc;
            check("wr_en", 32'(bus.o_WR_EN), 32'(exp_wr));
            if (exp_wr) begin
                check("wr_a1", 32'(bus.o_WR_ADDR1), wq[0].a1);
                check("wr_a2", 32'(bus.o_WR_ADDR2), wq[0].a2);
                void'(wq.pop_front());
            end
            exp_busy = (c >= 1) && (exp_done < 0 || c <= exp_done);
            check("done", 32'(bus.o_DONE), 32'(c == exp_done));
            check("busy", 32'(bus.o_BUSY), 32'(exp_busy));
        end
        if (rst_c < 0) begin
            check("rd_left", rq.size(), 0);
            check("wr_left", wq.size(), 0);
        end
    endtask

    initial begin
        logic [63:0] rd_basic;
        logic [63:0] rd_stall;
        logic [63:0] stall_m;
        rd_basic = m8(1, 2, 7, 8, 13, 14, 19, 20);
        rd_stall = m8(1, 3, 9, 10, 15, 16, 21, 22);
        stall_m  = (64'd1 << 2) | (64'd1 << 5);

        bus.i_START   = 1'b0;
        bus.i_INVERSE = 1'b0;
        bus.i_STALL   = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        cur_name = "reset";
        check_idle("reset");

        // Reset and start together: reset must win.
        @(negedge clk);
        rst         = 1'b1;
        bus.i_START = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        bus.i_START = 1'b0;
        #1;
        cur_name = "rst_vs_start";
        check_idle("rvs0");
        @(negedge clk);
        #1;
        check_idle("rvs1");

        run_check("basic",   1'b0, 64'd0,   rd_basic, -1, -1, 25);
        run_check("inverse", 1'b1, 64'd0,   rd_basic, -1, -1, 25);
        run_check("stall",   1'b0, stall_m, rd_stall, -1, -1, 27);
        run_check("abort",   1'b0, 64'd0,   rd_basic, -1, 10, -1);
        run_check("restart", 1'b0, 64'd0,   rd_basic, -1, -1, 25);
        run_check("poke",    1'b0, 64'd0,   rd_basic,  5, -1, 25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
